// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite layer: colour struct, raster
// geometry and the on-screen extent helper.
package sprite_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int COORD_W  = 10;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb4_t;

    // One extra bit over the pixel coordinate so edge + extent never wraps.
    function automatic logic [COORD_W:0] sprite_extent(input int size, input int shift);
        return (COORD_W + 1)'(size << shift);
    endfunction

endpackage

// File: rtl/sprite_palette.sv
// Fixed 16-entry palette mapping a sprite texel index to an RGB444 colour.
// Indices beyond the table decode to black.
module sprite_palette
    import sprite_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] idx,
    output rgb4_t            color
);

    always_comb begin
        color = '{r: 4'h0, g: 4'h0, b: 4'h0};
        case (32'(idx))
            0:  color = '{r: 4'h0, g: 4'h0, b: 4'h0};
            1:  color = '{r: 4'hF, g: 4'hF, b: 4'hF};
            2:  color = '{r: 4'hF, g: 4'h0, b: 4'h0};
            3:  color = '{r: 4'h0, g: 4'hF, b: 4'h0};
            4:  color = '{r: 4'h0, g: 4'h0, b: 4'hF};
            5:  color = '{r: 4'hF, g: 4'hF, b: 4'h0};
            6:  color = '{r: 4'h0, g: 4'hF, b: 4'hF};
            7:  color = '{r: 4'hF, g: 4'h0, b: 4'hF};
            8:  color = '{r: 4'h8, g: 4'h8, b: 4'h8};
            9:  color = '{r: 4'hC, g: 4'h6, b: 4'h2};
            10: color = '{r: 4'h2, g: 4'h6, b: 4'hC};
            11: color = '{r: 4'h6, g: 4'hC, b: 4'h2};
            12: color = '{r: 4'hF, g: 4'h8, b: 4'h0};
            13: color = '{r: 4'h8, g: 4'h0, b: 4'hF};
            14: color = '{r: 4'h4, g: 4'h4, b: 4'h4};
            15: color = '{r: 4'hC, g: 4'hC, b: 4'hC};
            default: ;
        endcase
    end

endmodule

// File: rtl/sprite_layer_renderer.sv
// Composites one scaled, animated, palette-indexed sprite over the background
// stream, with frame-synchronous position updates and ROM-latency alignment.
module sprite_layer_renderer
    import sprite_pkg::*;
#(
    parameter int IMG_W       = 32,
    parameter int IMG_H       = 32,
    parameter int SCALE_SHIFT = 1,
    parameter int N_FRAMES    = 4,
    parameter int ANIM_DIV    = 8,
    parameter int IDX_W       = 4,
    parameter int TRANSP_IDX  = 0,
    parameter int ROM_LAT     = 1,
    parameter int V_ACTIVE    = sprite_pkg::V_ACTIVE
) (
    input  logic                                      vga_clk,
    input  logic                                      reset,
    input  logic [9:0]                                DrawX,
    input  logic [9:0]                                DrawY,
    input  logic                                      blank,
    input  logic [3:0]                                bg_red,
    input  logic [3:0]                                bg_green,
    input  logic [3:0]                                bg_blue,
    input  logic [9:0]                                pos_x,
    input  logic [9:0]                                pos_y,
    input  logic                                      pos_valid,
    output logic                                      pos_ready,
    input  logic                                      enable,
    output logic [$clog2(N_FRAMES*IMG_W*IMG_H)-1:0]   rom_address,
    input  logic [IDX_W-1:0]                          rom_q,
    output logic [3:0]                                red,
    output logic [3:0]                                green,
    output logic [3:0]                                blue
);

    localparam int ADDR_W = $clog2(N_FRAMES * IMG_W * IMG_H);
    localparam int LX_W   = $clog2(IMG_W);
    localparam int LY_W   = $clog2(IMG_H);
    localparam int FR_W   = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam int DIV_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [COORD_W:0] EXT_X = sprite_extent(IMG_W, SCALE_SHIFT);
    localparam logic [COORD_W:0] EXT_Y = sprite_extent(IMG_H, SCALE_SHIFT);

    logic               frame_tick;
    logic               pending_full;
    logic [COORD_W-1:0] pend_x, pend_y, act_x, act_y;
    logic [FR_W-1:0]    anim_frame;
    logic [DIV_W-1:0]   anim_div_cnt;

    assign frame_tick = (DrawX == '0) && (DrawY == COORD_W'(V_ACTIVE));
    assign pos_ready  = !pending_full;

    // Commit and capture are exclusive: commit needs a full slot, capture an empty one.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            pending_full <= 1'b0;
            pend_x       <= '0;
            pend_y       <= '0;
            act_x        <= '0;
            act_y        <= '0;
        end else if (frame_tick && pending_full) begin
            act_x        <= pend_x;
            act_y        <= pend_y;
            pending_full <= 1'b0;
        end else if (pos_valid && !pending_full) begin
            pend_x       <= pos_x;
            pend_y       <= pos_y;
            pending_full <= 1'b1;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            anim_div_cnt <= '0;
            anim_frame   <= '0;
        end else if (frame_tick) begin
            if (anim_div_cnt == DIV_W'(ANIM_DIV - 1)) begin
                anim_div_cnt <= '0;
                anim_frame   <= (anim_frame == FR_W'(N_FRAMES - 1)) ? '0 : anim_frame + 1'b1;
            end else begin
                anim_div_cnt <= anim_div_cnt + 1'b1;
            end
        end
    end

    logic [COORD_W:0] px, py, ax, ay, off_x, off_y;
    logic [LX_W-1:0]  lx;
    logic [LY_W-1:0]  ly;
    logic             hit;
    logic [ADDR_W-1:0] addr_next;

    assign px    = {1'b0, DrawX};
    assign py    = {1'b0, DrawY};
    assign ax    = {1'b0, act_x};
    assign ay    = {1'b0, act_y};
    assign hit   = enable && (px >= ax) && (px < ax + EXT_X) && (py >= ay) && (py < ay + EXT_Y);
    assign off_x = px - ax;
    assign off_y = py - ay;
    assign lx    = LX_W'(off_x >> SCALE_SHIFT);
    assign ly    = LY_W'(off_y >> SCALE_SHIFT);
    assign addr_next = (ADDR_W'(anim_frame) << (LX_W + LY_W)) | (ADDR_W'(ly) << LX_W) | ADDR_W'(lx);

    // Stage S0 onward: address issue plus a side-band delay line matching the ROM.
    rgb4_t            bg_in;
    rgb4_t            bg_p [ROM_LAT+1];
    logic [ROM_LAT:0] vld_p, hit_p, blank_p;

    assign bg_in = '{r: bg_red, g: bg_green, b: bg_blue};

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            vld_p       <= '0;
            rom_address <= '0;
        end else begin
            vld_p <= {vld_p[ROM_LAT-1:0], 1'b1};
            if (hit)
                rom_address <= addr_next;
        end
    end

    always_ff @(posedge vga_clk) begin
        hit_p   <= {hit_p[ROM_LAT-1:0], hit};
        blank_p <= {blank_p[ROM_LAT-1:0], blank};
        bg_p[0] <= bg_in;
        for (int i = 1; i <= ROM_LAT; i++)
            bg_p[i] <= bg_p[i-1];
    end

    // Stage S_last: composite the aligned ROM texel over the delayed background.
    rgb4_t pal_rgb;
    rgb4_t rgb_out;

    sprite_palette #(.IDX_W(IDX_W)) u_palette (
        .idx   (rom_q),
        .color (pal_rgb)
    );

    always_ff @(posedge vga_clk) begin
        if (reset)
            rgb_out <= '{r: 4'h0, g: 4'h0, b: 4'h0};
        else if (!vld_p[ROM_LAT] || !blank_p[ROM_LAT])
            rgb_out <= '{r: 4'h0, g: 4'h0, b: 4'h0};
        else if (hit_p[ROM_LAT] && (rom_q != IDX_W'(TRANSP_IDX)))
            rgb_out <= pal_rgb;
        else
            rgb_out <= bg_p[ROM_LAT];
    end

    assign red   = rgb_out.r;
    assign green = rgb_out.g;
    assign blue  = rgb_out.b;

endmodule
